snoop_bus: RTL

- Shared snooping-bus controller for the MESI multiprocessor.
- Sits directly downstream of each processor's MESI controller and consumes its bus requests: read miss, write miss, invalidate.
- Arbitrates round-robin, broadcasts the winning transaction to all other caches, and collects their snoop responses (shared / dirty-abort).
- Performs owner write-back into a small internal main memory, then returns line data and a shared flag to the requester, which picks Shared vs Exclusive on a read miss.

---
 rtl/snoop_bus_if.sv | 32 +++
 rtl/snoop_bus.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/snoop_bus_if.sv
// Bus-side signal bundle between the processors' MESI controllers and the snoop bus controller.
// The slave modport is the controller's view; master is the processor/cache view.
interface snoop_bus_if #(
    parameter int NPROC  = 3,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 3
);
    logic [NPROC-1:0]        req;
    logic [2*NPROC-1:0]      req_op;
    logic [ADDR_W*NPROC-1:0] req_addr;
    logic [NPROC-1:0]        snoop_hit;
    logic [NPROC-1:0]        snoop_dirty;
    logic [DATA_W*NPROC-1:0] wb_data;
    logic [NPROC-1:0]        grant;
    logic                    bus_valid;
    logic [1:0]              bus_op;
    logic [ADDR_W-1:0]       bus_addr;
    logic [1:0]              bus_src;
    logic [NPROC-1:0]        done;
    logic [DATA_W-1:0]       resp_data;
    logic                    resp_shared;

    modport slave (
        input  req, req_op, req_addr, snoop_hit, snoop_dirty, wb_data,
        output grant, bus_valid, bus_op, bus_addr, bus_src, done, resp_data, resp_shared
    );

    modport master (
        output req, req_op, req_addr, snoop_hit, snoop_dirty, wb_data,
        input  grant, bus_valid, bus_op, bus_addr, bus_src, done, resp_data, resp_shared
    );
endinterface

// File: rtl/snoop_bus.sv
// Shared snooping-bus controller: round-robin arbitration, snoop broadcast, owner
// write-back into a small main memory, and line/shared-flag return to the requester.
module snoop_bus #(
    parameter int NPROC   = 3,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 3,
    parameter int MEM_LAT = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    snoop_bus_if.slave bus
);
    localparam int SRC_W = 2;
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_INV = 2'b10;

    typedef enum logic [2:0] {IDLE, BCAST, WB, MEM, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [SRC_W-1:0]   r_src, r_last, r_owner;
    logic [1:0]         r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_shared;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [NPROC-1:0]   r_grant, r_done;
    logic               r_bus_valid, r_resp_shared;
    logic [1:0]         r_bus_op;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [SRC_W-1:0]   r_bus_src;
    logic [DATA_W-1:0]  r_resp_data;

    logic               w_any, w_found, w_mem_last;
    int unsigned        w_idx;
    logic [SRC_W-1:0]   w_sel, w_owner, w_src_nxt;
    logic [1:0]         w_sel_op, w_op_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [NPROC-1:0]   w_hit_m, w_dirty_m, w_onehot_nxt;

    // Grant is one-hot on the requester, so it doubles as the self-snoop mask.
    assign w_hit_m    = bus.snoop_hit & ~r_grant;
    assign w_dirty_m  = bus.snoop_dirty & ~r_grant;
    assign w_mem_last = (r_state == MEM) && (r_cnt == '0);

    always_comb begin
        w_any = 1'b0;
        w_sel = r_last;
        w_idx = 0;
        for (int unsigned k = 1; k <= NPROC; k++) begin
            w_idx = (32'(r_last) + k) % NPROC;
            if (!w_any && bus.req[w_idx]) begin
                w_any = 1'b1;
                w_sel = SRC_W'(w_idx);
            end
        end
        w_sel_op = bus.req_op[2*w_sel +: 2];

        w_found = 1'b0;
        w_owner = '0;
        for (int unsigned i = 0; i < NPROC; i++) begin
            if (!w_found && w_dirty_m[i]) begin
                w_found = 1'b1;
                w_owner = SRC_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_op_nxt    = r_op;
        w_addr_nxt  = r_addr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BCAST;
                    w_src_nxt   = w_sel;
                    w_op_nxt    = w_sel_op[1] ? OP_INV : w_sel_op;
                    w_addr_nxt  = bus.req_addr[ADDR_W*w_sel +: ADDR_W];
                end
            end
            BCAST: begin
                if (r_op == OP_INV)  w_state_nxt = DONE;
                else if (w_found)    w_state_nxt = WB;
                else                 w_state_nxt = MEM;
            end
            WB:      w_state_nxt = MEM;
            MEM:     if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_onehot_nxt = NPROC'(1) << w_src_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_last        <= SRC_W'(NPROC - 1);
            r_src         <= '0;
            r_op          <= '0;
            r_addr        <= '0;
            r_owner       <= '0;
            r_shared      <= 1'b0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_bus_valid   <= 1'b0;
            r_bus_op      <= '0;
            r_bus_addr    <= '0;
            r_bus_src     <= '0;
            r_done        <= '0;
            r_resp_data   <= '0;
            r_resp_shared <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_op    <= w_op_nxt;
            r_addr  <= w_addr_nxt;
            if (r_state == IDLE && w_any) r_last <= w_sel;
            if (r_state == BCAST) begin
                r_shared <= |w_hit_m;
                r_owner  <= w_owner;
                r_cnt    <= CNT_W'(MEM_LAT - 1);
            end
            if (r_state == MEM && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (r_state == WB) r_mem[r_addr] <= bus.wb_data[r_owner*DATA_W +: DATA_W];

            r_grant       <= (w_state_nxt == IDLE)  ? '0 : w_onehot_nxt;
            r_bus_valid   <= (w_state_nxt == BCAST);
            r_bus_op      <= (w_state_nxt == BCAST) ? w_op_nxt   : '0;
            r_bus_addr    <= (w_state_nxt == BCAST) ? w_addr_nxt : '0;
            r_bus_src     <= (w_state_nxt == BCAST) ? w_src_nxt  : '0;
            r_done        <= (w_state_nxt == DONE)  ? w_onehot_nxt : '0;
            r_resp_data   <= w_mem_last ? r_mem[r_addr] : '0;
            r_resp_shared <= w_mem_last && (r_op == OP_RD) && r_shared;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.bus_valid   = r_bus_valid;
    assign bus.bus_op      = r_bus_op;
    assign bus.bus_addr    = r_bus_addr;
    assign bus.bus_src     = r_bus_src;
    assign bus.done        = r_done;
    assign bus.resp_data   = r_resp_data;
    assign bus.resp_shared = r_resp_shared;
endmodule
